// File: rtl/ram_copy_engine.sv
`default_nettype none
// ============================================================================
//  Module   : ram_copy_engine
//  Brief    : Single-clock block-move master for an 8x16 dual-port RAM.
//             On an accepted start it copies len words from src_addr to
//             dst_addr, one word at a time, in ascending address order.
//             Optional macro RAM_COPY_CHECKSUM_EN adds an XOR checksum output.
//  Revision : 1.0 - initial release
// ============================================================================
module ram_copy_engine #(
  parameter int DW = 16,
  parameter int AW = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [AW-1:0] src_addr,
  input  logic [AW-1:0] dst_addr,
  input  logic [AW:0]   len,
  output logic          busy,
  output logic          done,
  output logic          ram_re,
  output logic [AW-1:0] ram_rd_addr,
  input  logic [DW-1:0] ram_dout,
  output logic          ram_we,
  output logic [AW-1:0] ram_wr_addr,
  output logic [DW-1:0] ram_din
`ifdef RAM_COPY_CHECKSUM_EN
  ,
  output logic [DW-1:0] checksum
`endif
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD   = 3'd1,
    S_CAP  = 3'd2,
    S_WR   = 3'd3,
    S_DONE = 3'd4
  } state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] src_ptr_q, src_ptr_d;
  logic [AW-1:0] dst_ptr_q, dst_ptr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic [DW-1:0] data_q, data_d;
  // Address outputs are registers so they hold their value while strobes are low.
  logic [AW-1:0] rd_addr_q, rd_addr_d;
  logic [AW-1:0] wr_addr_q, wr_addr_d;
`ifdef RAM_COPY_CHECKSUM_EN
  logic [DW-1:0] csum_q, csum_d;
`endif

  // State and datapath registers, all cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      src_ptr_q <= '0;
      dst_ptr_q <= '0;
      cnt_q     <= '0;
      data_q    <= '0;
      rd_addr_q <= '0;
      wr_addr_q <= '0;
`ifdef RAM_COPY_CHECKSUM_EN
      csum_q    <= '0;
`endif
    end else begin
      state_q   <= state_d;
      src_ptr_q <= src_ptr_d;
      dst_ptr_q <= dst_ptr_d;
      cnt_q     <= cnt_d;
      data_q    <= data_d;
      rd_addr_q <= rd_addr_d;
      wr_addr_q <= wr_addr_d;
`ifdef RAM_COPY_CHECKSUM_EN
      csum_q    <= csum_d;
`endif
    end
  end

  // Next-state and datapath update; every target holds by default.
  always_comb begin
    state_d   = state_q;
    src_ptr_d = src_ptr_q;
    dst_ptr_d = dst_ptr_q;
    cnt_d     = cnt_q;
    data_d    = data_q;
    rd_addr_d = rd_addr_q;
    wr_addr_d = wr_addr_q;
`ifdef RAM_COPY_CHECKSUM_EN
    csum_d    = csum_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          src_ptr_d = src_addr;
          dst_ptr_d = dst_addr;
          cnt_d     = len;
`ifdef RAM_COPY_CHECKSUM_EN
          csum_d    = '0;
`endif
          if (len == '0) begin
            state_d = S_DONE;
          end else begin
            state_d   = S_RD;
            rd_addr_d = src_addr;
          end
        end
      end
      S_RD: begin
        state_d = S_CAP;
      end
      S_CAP: begin
        // RAM output was registered on the RD edge, so it is valid now.
        data_d    = ram_dout;
        wr_addr_d = dst_ptr_q;
        state_d   = S_WR;
      end
      S_WR: begin
        // Pointers wrap naturally at 2**AW.
        src_ptr_d = src_ptr_q + AW'(1);
        dst_ptr_d = dst_ptr_q + AW'(1);
        cnt_d     = cnt_q - (AW+1)'(1);
`ifdef RAM_COPY_CHECKSUM_EN
        csum_d    = csum_q ^ data_q;
`endif
        if (cnt_q == (AW+1)'(1)) begin
          state_d = S_DONE;
        end else begin
          state_d   = S_RD;
          rd_addr_d = src_ptr_q + AW'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Strobes decode directly from the state register, so RD and WR never overlap.
  assign busy        = (state_q != S_IDLE);
  assign done        = (state_q == S_DONE);
  assign ram_re      = (state_q == S_RD);
  assign ram_we      = (state_q == S_WR);
  assign ram_rd_addr = rd_addr_q;
  assign ram_wr_addr = wr_addr_q;
  assign ram_din     = data_q;
`ifdef RAM_COPY_CHECKSUM_EN
  assign checksum    = csum_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ram_copy_engine.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ram_copy_engine
//  Brief    : Self-checking bench for ram_copy_engine with a behavioural
//             registered-output RAM and a word-by-word copy reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ram_copy_engine;
  localparam int DW    = 16;
  localparam int AW    = 3;
  localparam int DEPTH = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] src_addr = '0;
  logic [AW-1:0] dst_addr = '0;
  logic [AW:0]   len = '0;
  logic          busy, done, ram_re, ram_we;
  logic [AW-1:0] ram_rd_addr, ram_wr_addr;
  logic [DW-1:0] ram_din;
  logic [DW-1:0] ram_dout = '0;
`ifdef RAM_COPY_CHECKSUM_EN
  logic [DW-1:0] checksum;
`endif

  logic          tb_we = 1'b0;
  logic [AW-1:0] tb_addr = '0;
  logic [DW-1:0] tb_data = '0;

  logic [DW-1:0] mem      [DEPTH];
  logic [DW-1:0] init_mem [DEPTH];
  logic [DW-1:0] exp_mem  [DEPTH];
  logic [DW-1:0] exp_csum;

  int tests_run = 0;
  int tests_failed = 0;

  int lat, n_writes, n_dones, idle_dones;
  bit busy_err, idle_err;
  logic [AW-1:0] rd_q[$];

  ram_copy_engine #(.DW(DW), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .src_addr(src_addr), .dst_addr(dst_addr), .len(len),
    .busy(busy), .done(done),
    .ram_re(ram_re), .ram_rd_addr(ram_rd_addr), .ram_dout(ram_dout),
    .ram_we(ram_we), .ram_wr_addr(ram_wr_addr), .ram_din(ram_din)
`ifdef RAM_COPY_CHECKSUM_EN
    , .checksum(checksum)
`endif
  );

  always #5 clk = ~clk;

  // RAM with registered read output; bench preload port shares the write side.
  always @(posedge clk) begin
    if (ram_we) mem[ram_wr_addr] <= ram_din;
    else if (tb_we) mem[tb_addr] <= tb_data;
    if (ram_re) ram_dout <= mem[ram_rd_addr];
  end

  task automatic load_mem();
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clk);
      tb_we = 1'b1; tb_addr = AW'(i); tb_data = init_mem[i];
    end
    @(negedge clk);
    tb_we = 1'b0;
    for (int i = 0; i < DEPTH; i++) exp_mem[i] = init_mem[i];
  endtask

  task automatic random_init();
    for (int i = 0; i < DEPTH; i++) init_mem[i] = DW'($urandom);
  endtask

  // Reference: ascending word-by-word copy with address wrap.
  task automatic model_copy(input int s, input int d, input int l);
    logic [DW-1:0] v;
    exp_csum = '0;
    for (int i = 0; i < l; i++) begin
      v = exp_mem[(s + i) % DEPTH];
      exp_mem[(d + i) % DEPTH] = v;
      exp_csum = exp_csum ^ v;
    end
  endtask

  // Issue one start and follow the copy; optionally spam start while busy.
  task automatic run_copy(input int s, input int d, input int l, input bit spam);
    @(negedge clk);
    src_addr = AW'(s); dst_addr = AW'(d); len = (AW+1)'(l); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = -1; n_writes = 0; n_dones = 0; idle_dones = 0;
    busy_err = 1'b0; idle_err = 1'b0;
    rd_q.delete();
    for (int cyc = 1; cyc <= 200; cyc++) begin
      if (ram_we) n_writes++;
      if (ram_re) rd_q.push_back(ram_rd_addr);
      if (busy !== 1'b1) busy_err = 1'b1;
      if (done === 1'b1) begin
        n_dones++; lat = cyc;
        if (spam) start = 1'b1;
        break;
      end
      if (spam) start = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
    start = 1'b0;
    for (int j = 0; j < 4; j++) begin
      @(posedge clk); #1;
      if (done === 1'b1) idle_dones++;
      if (busy !== 1'b0 || ram_we !== 1'b0 || ram_re !== 1'b0) idle_err = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    tests_run++;
    if ({busy, done, ram_re, ram_we} !== 4'b0000) begin
      tests_failed++;
      $display("FAIL reset_strobes: got %b expected 0000", {busy, done, ram_re, ram_we});
    end
    tests_run++;
    if ({ram_rd_addr, ram_wr_addr, ram_din} !== '0) begin
      tests_failed++;
      $display("FAIL reset_addr_data: got rd=%0d wr=%0d din=%h expected all 0", ram_rd_addr, ram_wr_addr, ram_din);
    end
`ifdef RAM_COPY_CHECKSUM_EN
    tests_run++;
    if (checksum !== '0) begin
      tests_failed++;
      $display("FAIL reset_checksum: got %h expected 0000", checksum);
    end
`endif
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    init_mem[0] = 16'h1111; init_mem[1] = 16'h2222; init_mem[2] = 16'h3333; init_mem[3] = 16'h4444;
    for (int i = 4; i < DEPTH; i++) init_mem[i] = '0;
    load_mem();
    model_copy(0, 4, 4);
    run_copy(0, 4, 4, 1'b0);
    tests_run++;
    if (lat !== 13) begin tests_failed++; $display("FAIL basic_latency: got %0d expected 13", lat); end
    tests_run++;
    if (busy_err || idle_err) begin tests_failed++; $display("FAIL basic_busy: got busy_err=%0d idle_err=%0d expected 0 0", busy_err, idle_err); end
    tests_run++;
    if (n_writes !== 4) begin tests_failed++; $display("FAIL basic_writes: got %0d expected 4", n_writes); end
    for (int i = 0; i < DEPTH; i++) begin
      tests_run++;
      if (mem[i] !== exp_mem[i]) begin tests_failed++; $display("FAIL basic_mem[%0d]: got %h expected %h", i, mem[i], exp_mem[i]); end
    end
`ifdef RAM_COPY_CHECKSUM_EN
    tests_run++;
    if (checksum !== 16'h4444) begin tests_failed++; $display("FAIL basic_checksum: got %h expected 4444", checksum); end
`endif
  endtask

  task automatic test_wrap();
    random_init();
    init_mem[6] = 16'hAAAA; init_mem[7] = 16'hBBBB;
    load_mem();
    model_copy(6, 0, 2);
    run_copy(6, 0, 2, 1'b0);
    tests_run++;
    if (rd_q.size() != 2) begin
      tests_failed++; $display("FAIL wrap_rd_count: got %0d expected 2", rd_q.size());
    end else if (rd_q[0] !== 3'd6 || rd_q[1] !== 3'd7) begin
      tests_failed++; $display("FAIL wrap_rd_seq: got %0d,%0d expected 6,7", rd_q[0], rd_q[1]);
    end
    tests_run++;
    if (mem[0] !== 16'hAAAA || mem[1] !== 16'hBBBB) begin
      tests_failed++; $display("FAIL wrap_data: got %h,%h expected aaaa,bbbb", mem[0], mem[1]);
    end
    for (int i = 0; i < DEPTH; i++) begin
      tests_run++;
      if (mem[i] !== exp_mem[i]) begin tests_failed++; $display("FAIL wrap_mem[%0d]: got %h expected %h", i, mem[i], exp_mem[i]); end
    end
  endtask

  task automatic test_len0();
    random_init();
    load_mem();
    run_copy(3, 5, 0, 1'b0);
    tests_run++;
    if (lat !== 1) begin tests_failed++; $display("FAIL len0_latency: got %0d expected 1", lat); end
    tests_run++;
    if (n_writes !== 0 || rd_q.size() != 0) begin
      tests_failed++; $display("FAIL len0_strobes: got writes=%0d reads=%0d expected 0 0", n_writes, rd_q.size());
    end
    for (int i = 0; i < DEPTH; i++) begin
      tests_run++;
      if (mem[i] !== init_mem[i]) begin tests_failed++; $display("FAIL len0_mem[%0d]: got %h expected %h", i, mem[i], init_mem[i]); end
    end
`ifdef RAM_COPY_CHECKSUM_EN
    tests_run++;
    if (checksum !== '0) begin tests_failed++; $display("FAIL len0_checksum: got %h expected 0000", checksum); end
`endif
  endtask

  task automatic test_overlap();
    random_init();
    init_mem[0] = 16'd1; init_mem[1] = 16'd2; init_mem[2] = 16'd3;
    load_mem();
    run_copy(0, 1, 2, 1'b0);
    tests_run++;
    if (mem[1] !== 16'd1 || mem[2] !== 16'd1) begin
      tests_failed++; $display("FAIL overlap_data: got %h,%h expected 0001,0001", mem[1], mem[2]);
    end
    tests_run++;
    if (mem[0] !== 16'd1 || mem[3] !== init_mem[3]) begin
      tests_failed++; $display("FAIL overlap_neighbours: got %h,%h expected 0001,%h", mem[0], mem[3], init_mem[3]);
    end
  endtask

  task automatic test_ignored_starts();
    int s, d, l;
    for (int it = 0; it < 3; it++) begin
      s = $urandom_range(0, 7); d = $urandom_range(0, 7); l = $urandom_range(1, 8);
      random_init();
      load_mem();
      model_copy(s, d, l);
      run_copy(s, d, l, 1'b1);
      tests_run++;
      if (n_dones !== 1 || idle_dones !== 0 || idle_err) begin
        tests_failed++;
        $display("FAIL ignored_dones: got dones=%0d extra=%0d idle_err=%0d expected 1 0 0", n_dones, idle_dones, idle_err);
      end
      tests_run++;
      if (n_writes !== l || lat !== 3 * l + 1) begin
        tests_failed++; $display("FAIL ignored_timing: got writes=%0d lat=%0d expected %0d %0d", n_writes, lat, l, 3 * l + 1);
      end
      for (int i = 0; i < DEPTH; i++) begin
        tests_run++;
        if (mem[i] !== exp_mem[i]) begin tests_failed++; $display("FAIL ignored_mem[%0d]: got %h expected %h", i, mem[i], exp_mem[i]); end
      end
    end
  endtask

  task automatic test_reset_midcopy();
    bit saw_we;
    random_init();
    load_mem();
    @(negedge clk);
    src_addr = 3'd2; dst_addr = 3'd5; len = 4'd8; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    saw_we = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (ram_we === 1'b1) begin saw_we = 1'b1; break; end
      @(posedge clk); #1;
    end
    tests_run++;
    if (!saw_we) begin tests_failed++; $display("FAIL midrst_reach_wr: got no WR cycle expected one within 20 cycles"); end
    #2;
    rst_n = 1'b0;
    #1;
    tests_run++;
    if ({busy, done, ram_re, ram_we} !== 4'b0000 || {ram_rd_addr, ram_wr_addr, ram_din} !== '0) begin
      tests_failed++;
      $display("FAIL midrst_outputs: got strobes=%b rd=%0d wr=%0d din=%h expected all 0",
               {busy, done, ram_re, ram_we}, ram_rd_addr, ram_wr_addr, ram_din);
    end
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      tests_run++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        tests_failed++; $display("FAIL midrst_hold: got done=%b busy=%b expected 0 0", done, busy);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    random_init();
    load_mem();
    model_copy(2, 5, 8);
    run_copy(2, 5, 8, 1'b0);
    tests_run++;
    if (lat !== 25 || n_writes !== 8 || n_dones !== 1) begin
      tests_failed++; $display("FAIL midrst_fresh: got lat=%0d writes=%0d dones=%0d expected 25 8 1", lat, n_writes, n_dones);
    end
    for (int i = 0; i < DEPTH; i++) begin
      tests_run++;
      if (mem[i] !== exp_mem[i]) begin tests_failed++; $display("FAIL midrst_mem[%0d]: got %h expected %h", i, mem[i], exp_mem[i]); end
    end
  endtask

  task automatic test_random();
    int s, d, l;
    for (int it = 0; it < 12; it++) begin
      s = $urandom_range(0, 7); d = $urandom_range(0, 7); l = $urandom_range(0, 8);
      random_init();
      load_mem();
      model_copy(s, d, l);
      run_copy(s, d, l, 1'b0);
      tests_run++;
      if (lat !== 3 * l + 1 || n_writes !== l || busy_err || idle_err) begin
        tests_failed++;
        $display("FAIL random_timing src=%0d dst=%0d len=%0d: got lat=%0d writes=%0d busy_err=%0d idle_err=%0d expected %0d %0d 0 0",
                 s, d, l, lat, n_writes, busy_err, idle_err, 3 * l + 1, l);
      end
      for (int i = 0; i < DEPTH; i++) begin
        tests_run++;
        if (mem[i] !== exp_mem[i]) begin tests_failed++; $display("FAIL random_mem[%0d] src=%0d dst=%0d len=%0d: got %h expected %h", i, s, d, l, mem[i], exp_mem[i]); end
      end
`ifdef RAM_COPY_CHECKSUM_EN
      tests_run++;
      if (checksum !== exp_csum) begin tests_failed++; $display("FAIL random_checksum: got %h expected %h", checksum, exp_csum); end
`endif
    end
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;
    test_reset();
    test_basic();
    test_wrap();
    test_len0();
    test_overlap();
    test_ignored_starts();
    test_reset_midcopy();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
`default_nettype wire
